// File: rtl/alu.sv
// 18-bit datapath ALU: add / sub / mul / div with registered result and
// OverFlow, Carry, Zero, Negative flags. Single-cycle combinational ops,
// one register stage, asynchronous active-high reset.
module alu #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             OverFlow,
  output logic             Carry,
  output logic             Zero,
  output logic             Negative
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             cy;
  } rsp_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  op_e              op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo;
  rsp_t             nxt;

  assign op = op_e'(ALUControl);

  // Shared arithmetic: 19-bit add, A + ~B + 1 subtract (carry-out = no borrow),
  // full-width unsigned product, and a divide guarded against B == 0.
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    dif  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    quo  = (B == '0) ? ALL_ONES : (A / B);
  end

  // Select the result and the op-specific OverFlow/Carry for this cycle.
  always_comb begin
    nxt = '0;
    unique case (op)
      OP_ADD: begin
        nxt.res = sum[WIDTH-1:0];
        nxt.cy  = sum[WIDTH];
        nxt.ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        nxt.res = dif[WIDTH-1:0];
        nxt.cy  = dif[WIDTH];
        nxt.ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        nxt.res = prod[WIDTH-1:0];
        nxt.cy  = |prod[2*WIDTH-1:WIDTH];
        nxt.ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        // Divide-by-zero saturates to all ones and raises OverFlow.
        nxt.res = quo;
        nxt.cy  = 1'b0;
        nxt.ovf = (B == '0);
      end
      default: nxt = '0;
    endcase
  end

  // Output register; Zero/Negative derive from the registered-next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result   <= '0;
      OverFlow <= 1'b0;
      Carry    <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
    end else begin
      Result   <= nxt.res;
      OverFlow <= nxt.ovf;
      Carry    <= nxt.cy;
      Zero     <= (nxt.res == '0);
      Negative <= nxt.res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations,
// a monitor pops one per clock after the edge and compares.
module tb_alu;
  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic [1:0]   ALUControl;
  logic [W-1:0] Result;
  logic         OverFlow, Carry, Zero, Negative;

  typedef struct {
    string        name;
    logic [W+3:0] exp;   // {Result, OverFlow, Carry, Zero, Negative}
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUControl(ALUControl),
    .Result(Result), .OverFlow(OverFlow), .Carry(Carry),
    .Zero(Zero), .Negative(Negative)
  );

  always #5 clk = ~clk;

  function automatic logic [W+3:0] outs();
    return {Result, OverFlow, Carry, Zero, Negative};
  endfunction

  task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got R=%h V=%b C=%b Z=%b N=%b, want R=%h V=%b C=%b Z=%b N=%b",
               name, got[W+3:4], got[3], got[2], got[1], got[0],
               exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one operation at the falling edge and queue its expected outputs.
  task automatic issue(input string name, input logic [1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic v, input logic c,
                       input logic z, input logic n);
    sb_t e;
    @(negedge clk);
    A = a; B = b; ALUControl = op;
    e.name = name;
    e.exp  = {r, v, c, z, n};
    sb.push_back(e);
  endtask

  // Monitor: each rising edge presents the result of the previous falling-edge issue.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.name, outs(), e.exp);
      end
    end
  end

  initial begin
    rst = 1'b1; A = '0; B = '0; ALUControl = 2'b00;
    @(posedge clk); #1;
    check("reset_state", outs(), '0);
    @(negedge clk); rst = 1'b0;

    //      name          op     A          B          Result     V     C     Z     N
    issue("add_10_5",   2'b00, 18'd10,    18'd5,     18'd15,    1'b0, 1'b0, 1'b0, 1'b0);
    issue("sub_zero",   2'b01, 18'd20,    18'd20,    18'd0,     1'b0, 1'b1, 1'b1, 1'b0);
    issue("sub_borrow", 2'b01, 18'h1FFFF, 18'h20000, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("mul_4_3",    2'b10, 18'd4,     18'd3,     18'd12,    1'b0, 1'b0, 1'b0, 1'b0);
    issue("mul_hi",     2'b10, 18'h3FFFF, 18'd2,     18'h3FFFE, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("div_20_5",   2'b11, 18'd20,    18'd5,     18'd4,     1'b0, 1'b0, 1'b0, 1'b0);
    issue("div_by_0",   2'b11, 18'd50,    18'd0,     18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    issue("add_wrap",   2'b00, 18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    issue("add_sovf",   2'b00, 18'h1FFFF, 18'd1,     18'h20000, 1'b1, 1'b0, 1'b0, 1'b1);

    // Let the queue drain, then hit reset mid-cycle with nonzero outputs held.
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", outs(), '0);
    @(posedge clk); #1;
    check("reset_hold", outs(), '0);
    @(negedge clk); rst = 1'b0;

    // Back-to-back through all ops, one new operation per cycle.
    issue("b2b_add",    2'b00, 18'd10,    18'd5,     18'd15,    1'b0, 1'b0, 1'b0, 1'b0);
    issue("b2b_sub",    2'b01, 18'd5,     18'd7,     18'h3FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    issue("b2b_mul",    2'b10, 18'h200,   18'h200,   18'd0,     1'b1, 1'b1, 1'b1, 1'b0);
    issue("b2b_div",    2'b11, 18'h3FFFF, 18'd3,     18'h15555, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("b2b_add_z",  2'b00, 18'h20000, 18'h20000, 18'd0,     1'b1, 1'b1, 1'b1, 1'b0);
    issue("b2b_sub_v",  2'b01, 18'h20000, 18'd1,     18'h1FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    issue("b2b_div_0",  2'b11, 18'd7,     18'd0,     18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
